dcache_resp_unit: RTL
=====================

Name: dcache_resp_unit

Overview:
- Data-side memory responder for the single-cycle/pipelined MIPS datapath; the other end of the dREN/dWEN/datomic request interface driven by the instruction decoder.
- Accepts one word-sized load/store request at a time and serves it from an internal word array after a programmable number of wait states, pulsing dhit for one cycle.
- Implements LL/SC semantics with a link register that is invalidated by local stores and by an external snoop port.

Parameters:
- DEPTH, 256, number of 32-bit words in the internal array; must be a power of two.
- LAT, 2, wait-state cycles inserted before dhit (0..15).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- dREN  in  1  load request
- dWEN  in  1  store request
- datomic  in  1  qualifies dREN as LL and dWEN as SC
- daddr  in  32  byte address; word index = daddr[log2(DEPTH)+1:2]; daddr[1:0] and upper bits ignored (aliasing wraps)
- dstore  in  32  store data
- snoop_valid  in  1  remote write observed this cycle
- snoop_addr  in  32  byte address of remote write, compared at word granularity
- dhit  out  1  request complete, high for exactly one cycle
- dload  out  32  load data, or SC result (1 = success, 0 = fail)
- link_valid  out  1  link register valid (debug/verification)

Behaviour:
- Reset (async, RST=1): state IDLE; dhit=0; dload=0; link_valid=0; link address=0; no array write occurs. Array contents are not reset. Reset asserted mid-request abandons the request with no write.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE: at an edge with dREN|dWEN=1, latch op, datomic, word index and dstore. Go to WAIT with cnt=LAT-1 if LAT>0, else go to ACCESS. Inputs that change after latching are ignored until IDLE.
- dREN and dWEN both high: treated as a store; dREN is ignored.
- WAIT: if cnt==0 go to ACCESS, else decrement cnt.
- Latency: request sampled at the end of cycle 0 -> dhit=1 in cycle LAT+1, exactly one cycle.
- ACCESS: dhit=1. At the exit edge, perform the array write if the write is enabled (see below). Go to DONE.
- DONE: dhit=0; inputs ignored for one cycle. Go to IDLE. This guarantees a request still held in the cycle after dhit is not served twice.
- dload register is loaded on the edge entering ACCESS and holds its value until the next entry into ACCESS:
  - Load/LL: dload = array[idx]. The read sees any write completed on an earlier edge.
  - Plain SW: dload unchanged.
  - SC: dload = {31'b0, sc_ok}.
- sc_ok is evaluated on the edge entering ACCESS: link_valid && link_addr==idx && !(snoop_valid && snoop word==link_addr on that same edge).
- Write enable: plain SW always writes; SC writes only if sc_ok.
- Link register updates, highest priority first:
  1. Snoop hit (snoop_valid && snoop word == link_addr), on any edge in any state -> link_valid=0.
  2. LL on the edge entering ACCESS -> link_addr=idx, link_valid=1. If a snoop to the same word arrives on that edge, link_valid=1; the snoop precedes the LL and LL takes the fresh value.
  3. SC on the edge entering ACCESS (success or fail) -> link_valid=0.
  4. Plain SW to link_addr on the edge entering ACCESS -> link_valid=0. SW to any other word leaves the link intact.
- A second LL overwrites link_addr.

Test Plan:
- LAT=2: SW addr 0x10 data 0xDEADBEEF held until dhit -> dhit in cycle 3 only; then LW 0x10 -> dhit in cycle 3, dload=0xDEADBEEF.
- LL 0x20 (array value 0x5), then SC 0x20 data 0x7 -> SC dload=1, link_valid=0; LW 0x20 returns 0x7.
- LL 0x20; snoop_valid with snoop_addr 0x23 (same word); SC 0x20 data 0x9 -> dload=0, LW 0x20 returns 0x5 unchanged.
- LL 0x20; SW 0x24 -> link_valid stays 1; SW 0x20 -> link_valid=0; subsequent SC 0x20 -> dload=0, no write.
- dREN and dWEN held for 6 cycles with LAT=0 -> dhit in cycle 1, DONE in cycle 2, second service with dhit in cycle 4; exactly two dhit pulses; store semantics each time.
- RST asserted during WAIT of SW 0x30 data 0x1 -> dhit=0, dload=0, link_valid=0 immediately; later LW 0x30 returns the prior contents (no write).

Source files
------------

// File: rtl/dcache_resp_unit.sv
// Data-side memory responder: one word load/store at a time with LAT wait states,
// plus an LL/SC link register that local stores and remote snoops invalidate.
module dcache_resp_unit #(
   parameter int DEPTH = 256,
   parameter int LAT   = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic        datomic,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   input  logic        snoop_valid,
   input  logic [31:0] snoop_addr,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        link_valid
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'((LAT > 0) ? LAT - 1 : 0);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WAIT   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   typedef struct packed {
      logic          wr;
      logic          atomic;
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
   } req_t;

   logic [1:0]    state;
   logic [3:0]    cnt;
   req_t          req_q;
   req_t          in_req;
   req_t          cur;
   logic          req_in;
   logic          enter_access;
   logic [AW-1:0] link_addr;
   logic          snoop_hit;
   logic          sc_ok;
   logic          wr_en_q;
   logic [31:0]   mem [DEPTH];

   // Both enables high is a store; dREN then carries no meaning.
   assign req_in        = dREN | dWEN;
   assign in_req.wr     = dWEN;
   assign in_req.atomic = datomic;
   assign in_req.idx    = daddr[AW+1:2];
   assign in_req.wdata  = dstore;

   // With LAT=0 ACCESS is entered straight from IDLE, before req_q holds the request.
   assign cur          = (state == IDLE) ? in_req : req_q;
   assign enter_access = ((state == IDLE) && req_in && (LAT == 0)) ||
                         ((state == WAIT) && (cnt == 4'd0));

   assign snoop_hit = snoop_valid && (snoop_addr[AW+1:2] == link_addr);
   assign sc_ok     = link_valid && (link_addr == cur.idx) && !snoop_hit;
   assign dhit      = (state == ACCESS);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= 4'd0;
         req_q <= '0;
      end else begin
         case (state)
            IDLE: if (req_in) begin
               req_q <= in_req;
               if (LAT > 0) begin
                  state <= WAIT;
                  cnt   <= CNT_INIT;
               end else begin
                  state <= ACCESS;
               end
            end
            WAIT: if (cnt == 4'd0) state <= ACCESS;
                  else             cnt   <= cnt - 4'd1;
            ACCESS: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dload      <= 32'd0;
         wr_en_q    <= 1'b0;
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else begin
         if (enter_access) begin
            wr_en_q <= cur.wr && (!cur.atomic || sc_ok);
            if (!cur.wr)        dload <= mem[cur.idx];
            else if (cur.atomic) dload <= {31'd0, sc_ok};
         end
         // An LL on the same edge as a snoop observes the post-snoop value, so it wins.
         if (enter_access && !cur.wr && cur.atomic) begin
            link_addr  <= cur.idx;
            link_valid <= 1'b1;
         end else if (snoop_hit) begin
            link_valid <= 1'b0;
         end else if (enter_access && cur.wr && cur.atomic) begin
            link_valid <= 1'b0;
         end else if (enter_access && cur.wr && (cur.idx == link_addr)) begin
            link_valid <= 1'b0;
         end
      end
   end

   // Array is not reset; reset forces IDLE so no write can slip through.
   always_ff @(posedge CLK) begin
      if ((state == ACCESS) && wr_en_q) mem[req_q.idx] <= req_q.wdata;
   end

   logic unused_bits;
   assign unused_bits = ^{daddr[31:AW+2], daddr[1:0], snoop_addr[31:AW+2], snoop_addr[1:0]};
endmodule
